sc_life_counter: RTL and testbench
==================================

# sc_life_counter

Frog lives register and death/respawn sequencer for the Frogger datapath. Receives collision hits and frame ticks, holds the current lives count, and drives the lives bus consumed by the life comparator (zero-lives detect). It also produces the respawn strobe for the frog position logic and a grace (invulnerability) window after each death.

## Interface
- LIFECOUNTER_DATAWIDTH, 2, width of lives bus
- LIFECOUNTER_INITLIVES, 3, lives loaded on game start and reset; must be 1..2^W-1
- LIFECOUNTER_GRACETICKS, 60, frame ticks of invulnerability after a death; 1..255
- SC_LIFECOUNTER_CLOCK_50  in  1  system clock, all state on rising edge
- SC_LIFECOUNTER_RESET_InLow  in  1  asynchronous, active-low reset
- SC_LIFECOUNTER_start_In  in  1  synchronous start/restart request, level sampled each cycle
- SC_LIFECOUNTER_hit_In  in  1  collision indication from hit detector, level; only rising edges count
- SC_LIFECOUNTER_tick_In  in  1  one-cycle frame tick (e.g. 60 Hz)
- SC_LIFECOUNTER_data_OutBUS  out  LIFECOUNTER_DATAWIDTH  current lives count, registered
- SC_LIFECOUNTER_respawn_Out  out  1  one-cycle pulse: reposition frog
- SC_LIFECOUNTER_grace_Out  out  1  high while in GRACE state
- SC_LIFECOUNTER_gameOver_Out  out  1  high while in GAMEOVER state

## Operation
- States: IDLE, ALIVE, GRACE, GAMEOVER. Encoding free; all outputs registered.
- Reset (async, RESET_InLow=0): state IDLE, lives=INITLIVES, grace counter=0, hit_d=0, respawn=0, grace=0, gameOver=0.
- Edge detect: hit_d <= hit_In every cycle in every state; hitEdge = hit_In & ~hit_d.
- start_In=1 in any state (highest priority, overrides hitEdge and tick): lives<=INITLIVES, grace counter<=0, state<=ALIVE, respawn pulse.
- IDLE: waits for start; hits and ticks ignored.
- ALIVE, hitEdge: if lives==1 -> lives<=0, state<=GAMEOVER, no respawn pulse. Else lives<=lives-1, counter<=GRACETICKS, state<=GRACE, respawn pulse.
- GRACE: hits ignored (hit_d still tracks). On tick: if counter==1 -> counter<=0, state<=ALIVE; else counter<=counter-1. Non-tick cycles hold.
- A hit held high across the whole GRACE window does not cause a death on return to ALIVE (no new edge).
- GAMEOVER: lives held at 0; hits and ticks ignored; exits only via start.
- Lives never decremented below 0, never incremented except by start/reset (no wrap).
- respawn_Out: high exactly one cycle, the cycle after the causing sample; zero otherwise.
- grace_Out = (state==GRACE); gameOver_Out = (state==GAMEOVER).

## Timing
- Inputs sampled at clock edge k; data_OutBUS, state flags and respawn valid after edge k (one-cycle latency).
- hit rising at sample k (hit_d=0): lives decremented and grace_Out high from edge k onward.
- Grace duration: exactly GRACETICKS tick pulses; grace_Out falls at the edge sampling the GRACETICKS-th tick.
- Tick coincident with a hitEdge in ALIVE: the hit is taken; tick not counted toward the new grace window.
- Reset mid-operation: all state cleared immediately, asynchronously; block returns to IDLE regardless of inputs.
- No combinational path from inputs to outputs.

## Test plan
- Reset then release, no start -> lives=3, IDLE, grace=0, gameOver=0, respawn=0; hits ignored (lives stays 3).
- start pulse -> ALIVE, lives=3, respawn high for exactly 1 cycle; hit rising -> lives=2, grace=1, respawn 1 cycle; second hit edge during grace -> lives stays 2.
- In GRACE, apply 59 ticks -> grace still 1; 60th tick -> grace=0, ALIVE; hit held high throughout -> no decrement after exit; drop and re-raise hit -> lives=1.
- Three separated deaths from start -> lives 3->2->1->0; final hit gives gameOver=1, no respawn pulse; further hits leave lives=0.
- From GAMEOVER, start -> lives=3, gameOver=0, respawn pulse; start and hit edge in same cycle during ALIVE -> lives=3, no decrement.
- Assert reset mid-GRACE (counter=30) -> outputs immediately lives=3, grace=0, IDLE; after release, ticks and hits ignored until start.

Source files
------------

// File: rtl/sc_life_counter.sv
// Frogger lives register and death/respawn sequencer: edge-detected hits cost a life,
// each non-final death opens a tick-counted grace window; all outputs are registered.
module sc_life_counter #(
  parameter int LIFECOUNTER_DATAWIDTH  = 2,
  parameter int LIFECOUNTER_INITLIVES  = 3,
  parameter int LIFECOUNTER_GRACETICKS = 60
) (
  input  logic                             SC_LIFECOUNTER_CLOCK_50,
  input  logic                             SC_LIFECOUNTER_RESET_InLow,
  input  logic                             SC_LIFECOUNTER_start_In,
  input  logic                             SC_LIFECOUNTER_hit_In,
  input  logic                             SC_LIFECOUNTER_tick_In,
  output logic [LIFECOUNTER_DATAWIDTH-1:0] SC_LIFECOUNTER_data_OutBUS,
  output logic                             SC_LIFECOUNTER_respawn_Out,
  output logic                             SC_LIFECOUNTER_grace_Out,
  output logic                             SC_LIFECOUNTER_gameOver_Out
);

  typedef enum logic [1:0] {IDLE, ALIVE, GRACE, GAMEOVER} state_t;

  localparam logic [LIFECOUNTER_DATAWIDTH-1:0] INIT_LIVES =
    LIFECOUNTER_DATAWIDTH'(LIFECOUNTER_INITLIVES);
  localparam logic [LIFECOUNTER_DATAWIDTH-1:0] ONE_LIFE = LIFECOUNTER_DATAWIDTH'(1);
  localparam logic [7:0] GRACE_LOAD = 8'(LIFECOUNTER_GRACETICKS);

  state_t                             state, state_nxt;
  logic [LIFECOUNTER_DATAWIDTH-1:0]   lives, lives_nxt;
  logic [7:0]                         count, count_nxt;
  logic                               hit_d;
  logic                               hit_edge;
  logic                               respawn, respawn_nxt;

  assign hit_edge = SC_LIFECOUNTER_hit_In & ~hit_d;

  always_ff @(posedge SC_LIFECOUNTER_CLOCK_50 or negedge SC_LIFECOUNTER_RESET_InLow) begin
    if (!SC_LIFECOUNTER_RESET_InLow) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    lives_nxt   = lives;
    count_nxt   = count;
    respawn_nxt = 1'b0;
    if (SC_LIFECOUNTER_start_In) begin
      state_nxt   = ALIVE;
      lives_nxt   = INIT_LIVES;
      count_nxt   = 8'd0;
      respawn_nxt = 1'b1;
    end else begin
      case (state)
        ALIVE: begin
          if (hit_edge) begin
            // Last life goes straight to game over without repositioning the frog.
            if (lives == ONE_LIFE) begin
              lives_nxt = '0;
              state_nxt = GAMEOVER;
            end else begin
              lives_nxt   = lives - ONE_LIFE;
              count_nxt   = GRACE_LOAD;
              state_nxt   = GRACE;
              respawn_nxt = 1'b1;
            end
          end
        end
        GRACE: begin
          if (SC_LIFECOUNTER_tick_In) begin
            if (count == 8'd1) begin
              count_nxt = 8'd0;
              state_nxt = ALIVE;
            end else begin
              count_nxt = count - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SC_LIFECOUNTER_CLOCK_50 or negedge SC_LIFECOUNTER_RESET_InLow) begin
    if (!SC_LIFECOUNTER_RESET_InLow) begin
      lives   <= INIT_LIVES;
      count   <= 8'd0;
      hit_d   <= 1'b0;
      respawn <= 1'b0;
    end else begin
      lives   <= lives_nxt;
      count   <= count_nxt;
      hit_d   <= SC_LIFECOUNTER_hit_In;
      respawn <= respawn_nxt;
    end
  end

  assign SC_LIFECOUNTER_data_OutBUS  = lives;
  assign SC_LIFECOUNTER_respawn_Out  = respawn;
  assign SC_LIFECOUNTER_grace_Out    = (state == GRACE);
  assign SC_LIFECOUNTER_gameOver_Out = (state == GAMEOVER);

endmodule

// File: tb/tb_sc_life_counter.sv
// Directed bench for sc_life_counter: a game-rules model is compared every cycle,
// with literal expectations pinning key points of the test sequence.
module tb_sc_life_counter;

  localparam int W = 2;
  localparam int INIT = 3;
  localparam int GT = 60;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         hit = 1'b0;
  logic         tick = 1'b0;
  logic [W-1:0] lives;
  logic         respawn;
  logic         grace;
  logic         game_over;

  int checks = 0;
  int failures = 0;

  sc_life_counter #(
    .LIFECOUNTER_DATAWIDTH(W),
    .LIFECOUNTER_INITLIVES(INIT),
    .LIFECOUNTER_GRACETICKS(GT)
  ) dut (
    .SC_LIFECOUNTER_CLOCK_50    (clk),
    .SC_LIFECOUNTER_RESET_InLow (rst_n),
    .SC_LIFECOUNTER_start_In    (start),
    .SC_LIFECOUNTER_hit_In      (hit),
    .SC_LIFECOUNTER_tick_In     (tick),
    .SC_LIFECOUNTER_data_OutBUS (lives),
    .SC_LIFECOUNTER_respawn_Out (respawn),
    .SC_LIFECOUNTER_grace_Out   (grace),
    .SC_LIFECOUNTER_gameOver_Out(game_over)
  );

  always #5 clk = ~clk;

  // Game model: mode 0 waiting, 1 playing, 2 invulnerable, 3 game over.
  int m_mode;
  int m_lives;
  int m_ticks_left;
  bit m_prev_hit;
  bit m_respawn;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_lives = INIT;
      m_ticks_left = 0;
      m_prev_hit = 0;
      m_respawn = 0;
    end else begin
      bit new_hit;
      new_hit = hit && !m_prev_hit;
      m_prev_hit = hit;
      m_respawn = 0;
      if (start) begin
        m_mode = 1;
        m_lives = INIT;
        m_ticks_left = 0;
        m_respawn = 1;
      end else if (m_mode == 1 && new_hit) begin
        m_lives = m_lives - 1;
        if (m_lives == 0) begin
          m_mode = 3;
        end else begin
          m_mode = 2;
          m_ticks_left = GT;
          m_respawn = 1;
        end
      end else if (m_mode == 2 && tick) begin
        m_ticks_left = m_ticks_left - 1;
        if (m_ticks_left == 0) m_mode = 1;
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("model_lives", int'(lives), m_lives);
    cmp("model_respawn", int'(respawn), int'(m_respawn));
    cmp("model_grace", int'(grace), (m_mode == 2) ? 1 : 0);
    cmp("model_gameover", int'(game_over), (m_mode == 3) ? 1 : 0);
  end

  task automatic cyc(input bit s, input bit h, input bit t);
    start = s;
    hit = h;
    tick = t;
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (3) cyc(0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0);
    cmp("reset_lives", int'(lives), 3);
    cmp("reset_grace", int'(grace), 0);
    cmp("reset_gameover", int'(game_over), 0);
    cmp("reset_respawn", int'(respawn), 0);

    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    cmp("idle_hits_ignored", int'(lives), 3);
    cyc(0, 0, 0);

    cyc(1, 0, 0);
    cmp("start_respawn", int'(respawn), 1);
    cmp("start_lives", int'(lives), 3);
    cyc(0, 0, 0);
    cmp("start_respawn_one_cycle", int'(respawn), 0);

    cyc(0, 1, 0);
    cmp("hit1_lives", int'(lives), 2);
    cmp("hit1_grace", int'(grace), 1);
    cmp("hit1_respawn", int'(respawn), 1);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    cmp("grace_hit_ignored", int'(lives), 2);

    for (int i = 0; i < GT - 1; i++) begin
      cyc(0, 1, 1);
      cyc(0, 1, 0);
    end
    cmp("grace_after_59_ticks", int'(grace), 1);
    cyc(0, 1, 1);
    cmp("grace_after_60_ticks", int'(grace), 0);
    repeat (5) cyc(0, 1, 0);
    cmp("held_hit_no_death", int'(lives), 2);

    cyc(0, 0, 0);
    cyc(0, 1, 1);
    cmp("hit2_lives", int'(lives), 1);
    cmp("hit2_grace", int'(grace), 1);
    for (int i = 0; i < GT - 1; i++) cyc(0, 0, 1);
    cmp("coincident_tick_not_counted", int'(grace), 1);
    cyc(0, 0, 1);
    cmp("hit2_grace_exit", int'(grace), 0);

    cyc(0, 1, 0);
    cmp("final_lives", int'(lives), 0);
    cmp("final_gameover", int'(game_over), 1);
    cmp("final_no_respawn", int'(respawn), 0);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    cmp("gameover_lives_hold", int'(lives), 0);

    cyc(1, 0, 0);
    cmp("restart_lives", int'(lives), 3);
    cmp("restart_gameover", int'(game_over), 0);
    cmp("restart_respawn", int'(respawn), 1);
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    cmp("start_beats_hit", int'(lives), 3);
    cyc(0, 0, 0);

    cyc(0, 1, 0);
    for (int i = 0; i < 30; i++) cyc(0, 0, 1);
    cmp("mid_grace_flag", int'(grace), 1);
    #1 rst_n = 1'b0;
    #1;
    cmp("async_rst_lives", int'(lives), 3);
    cmp("async_rst_grace", int'(grace), 0);
    cmp("async_rst_gameover", int'(game_over), 0);
    cyc(0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 1, 1);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    cmp("post_rst_ignored", int'(lives), 3);
    cmp("post_rst_grace", int'(grace), 0);
    cyc(1, 0, 0);
    cmp("post_rst_start", int'(respawn), 1);
    repeat (3) cyc(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
